station_dest_tracker: RTL and testbench



---
 rtl/robot_pkg.sv | 18 +
 rtl/watchdog_timer.sv | 47 ++++
 rtl/station_dest_tracker.sv | 143 ++++++++++++++
 tb/tb_station_dest_tracker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared types and constants for the station destination tracker
//
// Purpose: tracker FSM state type, command opcodes and station ID width.
// Ports:   none (package).

package robot_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    TRAVEL = 1'b1
  } trk_state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

  localparam int STN_ID_W = 6;

endpackage

// File: rtl/watchdog_timer.sv
// rtl/watchdog_timer.sv - travel watchdog with combinational terminal-count flag
//
// Purpose: counts enabled cycles since the last clear and flags the cycle in
//          which the count sits at TIMEOUT_CYCLES-1.
// Ports:   clk     - system clock
//          rst     - asynchronous active-high reset
//          clr     - synchronous clear to zero (wins over en)
//          en      - count enable
//          expired - high while count == TIMEOUT_CYCLES-1

module watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TERM_CNT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TERM_CNT);

  // Holding at terminal count keeps the counter from wrapping even if the
  // owner is slow to react to expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/station_dest_tracker.sv
// rtl/station_dest_tracker.sv - destination tracker driving go/arrived/lost
//
// Purpose: accepts GO/STOP commands, latches the destination station, drives
//          the drive-enable while travelling and compares each consumed
//          barcode ID against the destination.
// Ports:   clk, rst          - clock, asynchronous active-high reset
//          cmd_rdy, cmd      - command byte level handshake ([7:6] op, [5:0] dest)
//          clr_cmd_rdy       - one-cycle pulse consuming cmd
//          ID_vld, ID        - barcode ID level handshake ([5:0] used)
//          clr_ID_vld        - one-cycle pulse consuming ID
//          go                - drive enable, high in TRAVEL
//          dest_id           - latched destination
//          arrived, lost     - one-cycle result pulses
//          stn_cnt           - non-matching stations passed since last GO

module station_dest_tracker
  import robot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_rdy,
  input  logic [7:0]          cmd,
  output logic                clr_cmd_rdy,
  input  logic                ID_vld,
  input  logic [7:0]          ID,
  output logic                clr_ID_vld,
  output logic                go,
  output logic [STN_ID_W-1:0] dest_id,
  output logic                arrived,
  output logic                lost,
  output logic [CNT_W-1:0]    stn_cnt
);

  trk_state_t          state_q, state_d;
  logic [STN_ID_W-1:0] dest_id_q, dest_id_d;
  logic [CNT_W-1:0]    stn_cnt_q, stn_cnt_d;
  logic                go_q, go_d;
  logic                arrived_q, arrived_d;
  logic                lost_q, lost_d;
  logic                clr_cmd_rdy_q, clr_cmd_rdy_d;
  logic                clr_ID_vld_q, clr_ID_vld_d;

  logic cmd_acc, id_acc, tmr_clr, tmr_en, tmr_expired;
  logic unused_id_hi;

  assign unused_id_hi = ^ID[7:6];

  // The clr pulse masks the still-high level for the one cycle upstream
  // needs to drop it. A command always wins the cycle; the ID stays pending.
  assign cmd_acc = cmd_rdy && !clr_cmd_rdy_q;
  assign id_acc  = ID_vld && !clr_ID_vld_q && !cmd_acc;

  // Timer runs only in TRAVEL and restarts on any consumed command or ID.
  assign tmr_en  = (state_q == TRAVEL);
  assign tmr_clr = (state_q != TRAVEL) || cmd_acc || id_acc;

  watchdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    dest_id_d     = dest_id_q;
    stn_cnt_d     = stn_cnt_q;
    arrived_d     = 1'b0;
    lost_d        = 1'b0;
    clr_cmd_rdy_d = cmd_acc;
    clr_ID_vld_d  = id_acc;

    unique case (state_q)
      IDLE: begin
        if (cmd_acc && (cmd[7:6] == OP_GO)) begin
          state_d   = TRAVEL;
          dest_id_d = cmd[STN_ID_W-1:0];
          stn_cnt_d = '0;
        end
      end
      TRAVEL: begin
        if (cmd_acc) begin
          if (cmd[7:6] == OP_GO) begin
            dest_id_d = cmd[STN_ID_W-1:0];
            stn_cnt_d = '0;
          end else if (cmd[7:6] == OP_STOP) begin
            state_d = IDLE;
          end
        end else if (id_acc) begin
          if (ID[STN_ID_W-1:0] == dest_id_q) begin
            arrived_d = 1'b1;
            state_d   = IDLE;
          end else if (stn_cnt_q != {CNT_W{1'b1}}) begin
            stn_cnt_d = stn_cnt_q + CNT_W'(1);
          end
        end else if (tmr_expired) begin
          lost_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    go_d = (state_d == TRAVEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      dest_id_q     <= '0;
      stn_cnt_q     <= '0;
      go_q          <= 1'b0;
      arrived_q     <= 1'b0;
      lost_q        <= 1'b0;
      clr_cmd_rdy_q <= 1'b0;
      clr_ID_vld_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_id_q     <= dest_id_d;
      stn_cnt_q     <= stn_cnt_d;
      go_q          <= go_d;
      arrived_q     <= arrived_d;
      lost_q        <= lost_d;
      clr_cmd_rdy_q <= clr_cmd_rdy_d;
      clr_ID_vld_q  <= clr_ID_vld_d;
    end
  end

  assign go          = go_q;
  assign dest_id     = dest_id_q;
  assign stn_cnt     = stn_cnt_q;
  assign arrived     = arrived_q;
  assign lost        = lost_q;
  assign clr_cmd_rdy = clr_cmd_rdy_q;
  assign clr_ID_vld  = clr_ID_vld_q;

endmodule

// File: tb/tb_station_dest_tracker.sv
// tb/tb_station_dest_tracker.sv - scoreboard bench for station_dest_tracker

module tb_station_dest_tracker;

  localparam int TMO = 16;
  localparam int CW  = 4;

  localparam logic [2:0] K_CMD = 3'd1;
  localparam logic [2:0] K_ID  = 3'd2;
  localparam logic [2:0] K_ARR = 3'd3;
  localparam logic [2:0] K_LST = 3'd4;

  typedef struct packed {
    int          cyc;
    logic [2:0]  kind;
    logic [5:0]  dest;
    logic [CW-1:0] stn;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_rdy = 1'b0;
  logic [7:0]    cmd = 8'h00;
  logic          clr_cmd_rdy;
  logic          ID_vld = 1'b0;
  logic [7:0]    ID = 8'h00;
  logic          clr_ID_vld;
  logic          go;
  logic [5:0]    dest_id;
  logic          arrived;
  logic          lost;
  logic [CW-1:0] stn_cnt;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  station_dest_tracker #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .clr_cmd_rdy(clr_cmd_rdy),
    .ID_vld     (ID_vld),
    .ID         (ID),
    .clr_ID_vld (clr_ID_vld),
    .go         (go),
    .dest_id    (dest_id),
    .arrived    (arrived),
    .lost       (lost),
    .stn_cnt    (stn_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed pulse becomes a timestamped event for the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (clr_cmd_rdy) obs_q.push_back(ev_t'{cyc, K_CMD, dest_id, stn_cnt});
      if (clr_ID_vld)  obs_q.push_back(ev_t'{cyc, K_ID,  dest_id, stn_cnt});
      if (arrived)     obs_q.push_back(ev_t'{cyc, K_ARR, dest_id, stn_cnt});
      if (lost)        obs_q.push_back(ev_t'{cyc, K_LST, dest_id, stn_cnt});
    end
  end

  // Upstream model: drop a level once its clear pulse is seen.
  task automatic step();
    @(posedge clk);
    #1;
    if (clr_cmd_rdy) cmd_rdy = 1'b0;
    if (clr_ID_vld)  ID_vld  = 1'b0;
  endtask

  task automatic test_reset();
    ev_t e, o;
    step();
    n_cmp++; if (go !== 1'b0)      begin n_fail++; $display("FAIL reset_go got=%b want=0", go); end
    n_cmp++; if (dest_id !== 6'h0) begin n_fail++; $display("FAIL reset_dest got=%h want=00", dest_id); end
    n_cmp++; if (stn_cnt !== '0)   begin n_fail++; $display("FAIL reset_stn got=%0d want=0", stn_cnt); end
    n_cmp++; if ({arrived, lost, clr_cmd_rdy, clr_ID_vld} !== 4'b0)
      begin n_fail++; $display("FAIL reset_pulses got=%b want=0000", {arrived, lost, clr_cmd_rdy, clr_ID_vld}); end
    rst = 1'b0;
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL reset_ev missing want kind=%0d cyc=%0d", e.kind, e.cyc); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++;
        $display("FAIL reset_ev got cyc=%0d kind=%0d dest=%h stn=%0d want cyc=%0d kind=%0d dest=%h stn=%0d", o.cyc, o.kind, o.dest, o.stn, e.cyc, e.kind, e.dest, e.stn); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_extra got=%0d events want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_go();
    ev_t e, o;
    int c;
    c = cyc; cmd = 8'h45; cmd_rdy = 1'b1;
    exp_q.push_back(ev_t'{c + 1, K_CMD, 6'h05, 4'd0});
    step();
    n_cmp++; if (go !== 1'b1)       begin n_fail++; $display("FAIL go_level got=%b want=1", go); end
    n_cmp++; if (dest_id !== 6'h05) begin n_fail++; $display("FAIL go_dest got=%h want=05", dest_id); end
    step();
    n_cmp++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL go_clr_width got=%b want=0", clr_cmd_rdy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL go_ev missing want kind=%0d cyc=%0d", e.kind, e.cyc); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++;
        $display("FAIL go_ev got cyc=%0d kind=%0d dest=%h stn=%0d want cyc=%0d kind=%0d dest=%h stn=%0d", o.cyc, o.kind, o.dest, o.stn, e.cyc, e.kind, e.dest, e.stn); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL go_extra got=%0d events want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_ids();
    ev_t e, o;
    int c;
    c = cyc; ID = 8'h03; ID_vld = 1'b1;
    exp_q.push_back(ev_t'{c + 1, K_ID, 6'h05, 4'd1});
    step(); step();
    n_cmp++; if (stn_cnt !== 4'd1) begin n_fail++; $display("FAIL ids_stn got=%0d want=1", stn_cnt); end
    n_cmp++; if (go !== 1'b1)      begin n_fail++; $display("FAIL ids_go_kept got=%b want=1", go); end
    c = cyc; ID = 8'hC5; ID_vld = 1'b1;   // upper bits must be ignored
    exp_q.push_back(ev_t'{c + 1, K_ID,  6'h05, 4'd1});
    exp_q.push_back(ev_t'{c + 1, K_ARR, 6'h05, 4'd1});
    step();
    n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL ids_go_drop got=%b want=0", go); end
    step();
    n_cmp++; if (arrived !== 1'b0) begin n_fail++; $display("FAIL ids_arr_width got=%b want=0", arrived); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL ids_ev missing want kind=%0d cyc=%0d", e.kind, e.cyc); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++;
        $display("FAIL ids_ev got cyc=%0d kind=%0d dest=%h stn=%0d want cyc=%0d kind=%0d dest=%h stn=%0d", o.cyc, o.kind, o.dest, o.stn, e.cyc, e.kind, e.dest, e.stn); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ids_extra got=%0d events want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    ev_t e, o;
    int c;
    c = cyc; cmd = 8'h47; cmd_rdy = 1'b1;
    exp_q.push_back(ev_t'{c + 1,   K_CMD, 6'h07, 4'd0});
    exp_q.push_back(ev_t'{c + TMO + 1, K_LST, 6'h07, 4'd0});
    step();
    n_cmp++; if (go !== 1'b1) begin n_fail++; $display("FAIL tmo_go got=%b want=1", go); end
    for (int i = 1; i < TMO; i++) step();
    n_cmp++; if (lost !== 1'b0) begin n_fail++; $display("FAIL tmo_early got=%b want=0", lost); end
    step();
    n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL tmo_go_drop got=%b want=0", go); end
    step();
    n_cmp++; if ({go, lost} !== 2'b00) begin n_fail++; $display("FAIL tmo_after got=%b want=00", {go, lost}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL tmo_ev missing want kind=%0d cyc=%0d", e.kind, e.cyc); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++;
        $display("FAIL tmo_ev got cyc=%0d kind=%0d dest=%h stn=%0d want cyc=%0d kind=%0d dest=%h stn=%0d", o.cyc, o.kind, o.dest, o.stn, e.cyc, e.kind, e.dest, e.stn); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL tmo_extra got=%0d events want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_priority();
    ev_t e, o;
    int c;
    c = cyc; cmd = 8'h45; cmd_rdy = 1'b1;
    exp_q.push_back(ev_t'{c + 1, K_CMD, 6'h05, 4'd0});
    step(); step();
    c = cyc; cmd = 8'h47; cmd_rdy = 1'b1; ID = 8'h07; ID_vld = 1'b1;
    exp_q.push_back(ev_t'{c + 1, K_CMD, 6'h07, 4'd0});
    exp_q.push_back(ev_t'{c + 2, K_ID,  6'h07, 4'd0});
    exp_q.push_back(ev_t'{c + 2, K_ARR, 6'h07, 4'd0});
    step();
    n_cmp++; if (dest_id !== 6'h07) begin n_fail++; $display("FAIL pri_dest got=%h want=07", dest_id); end
    n_cmp++; if (clr_ID_vld !== 1'b0) begin n_fail++; $display("FAIL pri_id_early got=%b want=0", clr_ID_vld); end
    step();
    n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL pri_go_drop got=%b want=0", go); end
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL pri_ev missing want kind=%0d cyc=%0d", e.kind, e.cyc); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++;
        $display("FAIL pri_ev got cyc=%0d kind=%0d dest=%h stn=%0d want cyc=%0d kind=%0d dest=%h stn=%0d", o.cyc, o.kind, o.dest, o.stn, e.cyc, e.kind, e.dest, e.stn); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL pri_extra got=%0d events want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_stop_reserved();
    ev_t e, o;
    int c;
    c = cyc; cmd = 8'h45; cmd_rdy = 1'b1;
    exp_q.push_back(ev_t'{c + 1, K_CMD, 6'h05, 4'd0});
    step(); step();
    c = cyc; cmd = 8'h00; cmd_rdy = 1'b1;
    exp_q.push_back(ev_t'{c + 1, K_CMD, 6'h05, 4'd0});
    step();
    n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL stop_go got=%b want=0", go); end
    step();
    c = cyc; cmd = 8'hC5 ^ 8'h03; cmd_rdy = 1'b1;   // reserved op, dest 06
    exp_q.push_back(ev_t'{c + 1, K_CMD, 6'h05, 4'd0});
    step();
    n_cmp++; if (go !== 1'b0)       begin n_fail++; $display("FAIL rsv_go got=%b want=0", go); end
    n_cmp++; if (dest_id !== 6'h05) begin n_fail++; $display("FAIL rsv_dest got=%h want=05", dest_id); end
    step(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL stop_ev missing want kind=%0d cyc=%0d", e.kind, e.cyc); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++;
        $display("FAIL stop_ev got cyc=%0d kind=%0d dest=%h stn=%0d want cyc=%0d kind=%0d dest=%h stn=%0d", o.cyc, o.kind, o.dest, o.stn, e.cyc, e.kind, e.dest, e.stn); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stop_extra got=%0d events want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_travel();
    ev_t e, o;
    int c;
    c = cyc; cmd = 8'h49; cmd_rdy = 1'b1;
    exp_q.push_back(ev_t'{c + 1, K_CMD, 6'h09, 4'd0});
    step(); step();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({go, arrived, lost, clr_cmd_rdy, clr_ID_vld} !== 5'b0)
      begin n_fail++; $display("FAIL rmid_pulses got=%b want=00000", {go, arrived, lost, clr_cmd_rdy, clr_ID_vld}); end
    n_cmp++; if (dest_id !== 6'h0) begin n_fail++; $display("FAIL rmid_dest got=%h want=00", dest_id); end
    ID = 8'h09; ID_vld = 1'b1;
    step(); step();
    c = cyc; rst = 1'b0;
    exp_q.push_back(ev_t'{c + 1, K_ID, 6'h00, 4'd0});
    step();
    n_cmp++; if (go !== 1'b0) begin n_fail++; $display("FAIL rmid_go got=%b want=0", go); end
    step(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL rmid_ev missing want kind=%0d cyc=%0d", e.kind, e.cyc); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++;
        $display("FAIL rmid_ev got cyc=%0d kind=%0d dest=%h stn=%0d want cyc=%0d kind=%0d dest=%h stn=%0d", o.cyc, o.kind, o.dest, o.stn, e.cyc, e.kind, e.dest, e.stn); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_extra got=%0d events want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_go();
    test_ids();
    test_timeout();
    test_priority();
    test_stop_reserved();
    test_reset_mid_travel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
